// File: rtl/dump_ctrl_if.sv
// Bundle between dump_ctrl and its neighbours: command/capture control,
// shared capture RAM read port and the UART response handshake.
interface dump_ctrl_if #(
    parameter int ADDR_W = 9
) ();
    logic              dump;
    logic [1:0]        dump_ch;
    logic              capture_done;
    logic [ADDR_W-1:0] addr_ptr;
    logic [7:0]        ch1_rdata;
    logic [7:0]        ch2_rdata;
    logic [7:0]        ch3_rdata;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        resp_data;
    logic              send_resp;
    logic              resp_sent;
    logic              clr_cap_done;
    logic              dump_done;
    logic              dump_err;
    logic              busy;

    modport master (
        input  dump, dump_ch, capture_done, addr_ptr,
        input  ch1_rdata, ch2_rdata, ch3_rdata, resp_sent,
        output en, we, addr, resp_data, send_resp,
        output clr_cap_done, dump_done, dump_err, busy
    );

    modport slave (
        output dump, dump_ch, capture_done, addr_ptr,
        output ch1_rdata, ch2_rdata, ch3_rdata, resp_sent,
        input  en, we, addr, resp_data, send_resp,
        input  clr_cap_done, dump_done, dump_err, busy
    );
endinterface

// File: rtl/dump_ctrl.sv
// Capture-RAM dump sequencer: streams DEPTH bytes of one channel, oldest
// sample first, through the UART response handshake one byte at a time.
module dump_ctrl #(
    parameter int         DEPTH    = 512,
    parameter int         ADDR_W   = 9,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input logic        clk,
    input logic        rst_n,
    dump_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, RD, LAT, SEND, WAIT, DONE, ERR, ERR_WAIT
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [1:0]        ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        sel_rdata;
    logic              en_c, send_c, done_c, clr_c, err_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        case (ch_q)
            2'b00:   sel_rdata = bus.ch1_rdata;
            2'b01:   sel_rdata = bus.ch2_rdata;
            default: sel_rdata = bus.ch3_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        en_c    = 1'b0;
        send_c  = 1'b0;
        done_c  = 1'b0;
        clr_c   = 1'b0;
        err_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dump && bus.capture_done) begin
                    ch_d   = bus.dump_ch;
                    addr_d = bus.addr_ptr;
                    cnt_d  = '0;
                    if (bus.dump_ch == 2'b11) begin
                        data_d  = ERR_BYTE;
                        state_d = ERR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                en_c    = 1'b1;
                state_d = LAT;
            end
            // RAM has one clock of read latency, so data is captured here
            LAT: begin
                data_d  = sel_rdata;
                state_d = SEND;
            end
            SEND: begin
                send_c  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.resp_sent) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = (cnt_q == LAST) ? DONE : RD;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                clr_c   = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                send_c  = 1'b1;
                state_d = ERR_WAIT;
            end
            // Capture is kept on an invalid channel: no clr_cap_done here
            ERR_WAIT: begin
                if (bus.resp_sent) begin
                    done_c  = 1'b1;
                    err_c   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.en           = en_c;
    assign bus.we           = 1'b0;
    assign bus.addr         = addr_q;
    assign bus.resp_data    = data_q;
    assign bus.send_resp    = send_c;
    assign bus.clr_cap_done = clr_c;
    assign bus.dump_done    = done_c;
    assign bus.dump_err     = err_c;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: doc/dump_ctrl.md
Name: dump_ctrl

Overview:
Sequences a capture-RAM dump to the HOST.
- On a dump request it reads DEPTH samples of the selected channel from the shared capture RAM.
- Reads start at the oldest sample (write pointer) and wrap circularly.
- Each byte goes out through the UART response handshake, one at a time.
- Sits between Command_Config (dump/dump_ch), the capture block (addr_ptr, capture_done, clr_cap_done) and the RAM/UART ports of dig_core.
- Owns the RAM en/we/addr during a dump.

Parameters:
DEPTH, 512, samples per channel dumped.
ADDR_W, 9, RAM address width; DEPTH = 2**ADDR_W.
ERR_BYTE, 8'hEE, byte sent for an invalid channel select.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
dump  in  1  one-cycle dump request
dump_ch  in  2  00=ch1, 01=ch2, 10=ch3, 11=invalid
capture_done  in  1  capture complete, RAM holds valid data
addr_ptr  in  ADDR_W  capture write pointer, i.e. the oldest sample
ch1_rdata  in  8  RAM ch1 read data
ch2_rdata  in  8  RAM ch2 read data
ch3_rdata  in  8  RAM ch3 read data
en  out  1  RAM enable
we  out  1  RAM write enable (always 0 from this block)
addr  out  ADDR_W  RAM read address
resp_data  out  8  byte to UART
send_resp  out  1  one-cycle send strobe
resp_sent  in  1  UART byte finished
clr_cap_done  out  1  one-cycle pulse at end of dump
dump_done  out  1  one-cycle pulse at end of dump
dump_err  out  1  one-cycle pulse with dump_done for an invalid channel
busy  out  1  high from accept to dump_done inclusive

Behaviour:
Reset values:
- All outputs 0.
- State IDLE.
- Byte counter, address register and channel latch 0.
- Reset mid-dump aborts immediately with no done pulse.

States: IDLE, RD, LAT, SEND, WAIT, DONE, ERR, ERR_WAIT.

IDLE:
- dump=1 with capture_done=1 is accepted.
- On accept: latch dump_ch; load addr register from addr_ptr; clear counter.
- Next state RD if channel is valid, ERR if dump_ch=11.
- dump with capture_done=0 is ignored; stay IDLE, no response.

RD:
- en=1, addr=addr register, we=0. Go to LAT.
- RAM read latency is 1 clk: data is valid in LAT.

LAT:
- Register the selected chX_rdata into resp_data. Go to SEND.

SEND:
- send_resp=1 for exactly one cycle. Go to WAIT.

WAIT:
- resp_data held stable.
- On resp_sent: addr register = (addr+1) mod DEPTH; counter+1.
- If the counter was DEPTH-1, go to DONE; otherwise go to RD.
- resp_sent is ignored in every state except WAIT and ERR_WAIT.

DONE:
- dump_done=1 and clr_cap_done=1 for one cycle, then IDLE.

ERR:
- resp_data=ERR_BYTE, send_resp=1 for one cycle. Go to ERR_WAIT.

ERR_WAIT:
- On resp_sent: dump_done=1 and dump_err=1 for one cycle, then IDLE.
- clr_cap_done is NOT pulsed, so the capture is kept.

Outputs and sequencing rules:
- en is high only in RD. addr holds its last value otherwise.
- Exactly DEPTH send_resp pulses per valid dump.
- Byte order is addr_ptr, addr_ptr+1, ..., wrapping 511→0, ending at addr_ptr-1.
- Wrap: the address is ADDR_W bits and rolls naturally. The counter is ADDR_W+1 bits or compares to DEPTH-1.
- Minimum spacing between send_resp pulses: 4 clks plus UART time.
- dump while busy is ignored, with no effect on the latch or counter.
- Changes on dump_ch or addr_ptr after accept have no effect.
- resp_sent in the same cycle as send_resp (SEND state) is ignored. Only resp_sent in WAIT/ERR_WAIT advances the state.
- capture_done falling mid-dump has no effect.

Test Plan:
1. Reset sequence:
   - Stimulus: reset mid-dump, after 100 bytes sent.
   - Required: all outputs 0 within the reset cycle; no dump_done. A subsequent dump restarts from byte 0.
2. Full dump with wrap-around:
   - Stimulus: RAM ch2[i]=i[7:0], addr_ptr=9'd500, capture_done=1, dump with dump_ch=01; UART model answers resp_sent 10 clks after each send_resp.
   - Required: 512 bytes in the order 0xF4..0xFF, 0x00..0xF3; addresses 500..511, 0..499.
   - Required: one dump_done and one clr_cap_done after the 512th resp_sent; busy falls the cycle after.
3. Invalid channel:
   - Stimulus: dump with dump_ch=11.
   - Required: one send_resp with resp_data=0xEE; after resp_sent, dump_done=1 and dump_err=1; clr_cap_done stays 0; en never asserts.
4. Not ready:
   - Stimulus: dump with capture_done=0.
   - Required: no send_resp, busy stays 0, en stays 0.
5. Ignored inputs while busy:
   - Stimulus: dump pulses during an active ch1 dump; spurious resp_sent during RD/LAT/SEND; dump_ch changed to 10 mid-dump.
   - Required: still exactly 512 bytes, all from ch1; counter unaffected.
6. Fastest UART:
   - Stimulus: resp_sent asserted the cycle after send_resp, with addr_ptr=0.
   - Required: send_resp spacing exactly 4 clks; addresses 0..511; we=0 throughout.
